xadac_vload_mem: RTL and testbench
==================================

# xadac_vload_mem

Memory-side read engine for the XADAC vector load path. It accepts single-ID read requests on an AXI-style AR channel and splits each one into `Beats` word reads on a pipelined OBI-style memory port. It assembles the returned words into one `VecDataT` line and returns that line with the request ID on an AXI-style R channel. It sits directly downstream of the vector load unit's AR/R master ports, between that unit and the data memory or interconnect.

## Interface
- `MemDataWidth`, default 32: memory port data width in bits. Must divide `VectorWidth` from `xadac_pkg`.
- `Beats`, default `VectorWidth/MemDataWidth`: memory words per vector line. Derived; do not override.
- `MaxOutstanding`, default 2: maximum granted memory reads awaiting `mem_rvalid`.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: one clock; reset is asynchronous and active-low.
- `axi_ar_id` in `IdT`: request ID.
- `axi_ar_addr` in `AddrT`: byte address of the vector line.
- `axi_ar_valid` in 1: request valid.
- `axi_ar_ready` out 1: request accepted.
- `axi_r_id` out `IdT`: ID of the returned line.
- `axi_r_data` out `VecDataT`: assembled line.
- `axi_r_valid` out 1: response valid.
- `axi_r_ready` in 1: response accepted.
- `mem_req` out 1: word read request.
- `mem_addr` out `AddrT`: word byte address.
- `mem_gnt` in 1: request granted.
- `mem_rvalid` in 1: read data valid. Responses arrive in order.
- `mem_rdata` in `MemDataWidth`: read data.

## Operation
- FSM with states IDLE, FETCH and RESP. Reset state is IDLE.
- **IDLE**
  - `axi_ar_ready`=1.
  - On an AR handshake: latch the ID and base address, clear `issue_cnt`, `rx_cnt` and `line`, and go to FETCH.
- **FETCH**
  - `mem_req`=1 while `issue_cnt`<`Beats` and outstanding<`MaxOutstanding`.
  - `mem_addr` = base + `issue_cnt`*(`MemDataWidth`/8), computed modulo 2^`AddrWidth` (wraps silently).
  - A cycle with `mem_req && mem_gnt` increments `issue_cnt` and the outstanding count.
  - A cycle with `mem_rvalid` writes `mem_rdata` into `line[rx_cnt*MemDataWidth +: MemDataWidth]`, increments `rx_cnt` and decrements the outstanding count.
  - A grant and an rvalid in the same cycle leave the outstanding count unchanged.
  - When `rx_cnt` reaches `Beats`, go to RESP.
- **RESP**
  - `axi_r_valid`=1, with `axi_r_id`/`axi_r_data` taken from the latched ID and `line`.
  - Hold all three until `axi_r_ready`. On the R handshake, go to IDLE.
- `mem_rvalid` with outstanding=0, in any state, is dropped. No counter or data changes.
- `mem_req` deasserts only after a grant. `mem_addr` stays stable while `mem_req && !mem_gnt`.
- Exactly one AR transaction is in flight. A new AR is not accepted until the R handshake completes.

## Timing
- Reset values:
  - `axi_ar_ready`=0 during reset, 1 in the first cycle after reset release (IDLE).
  - `axi_r_valid`=0, `axi_r_id`='0, `axi_r_data`='0.
  - `mem_req`=0, `mem_addr`='0.
  - All counters 0.
- All outputs are registered or decoded from FSM state only. There is no combinational path from any input to any output.
- Latency, with `mem_gnt` tied 1 and `mem_rvalid` one cycle after grant:
  - AR handshake at cycle 0.
  - `mem_req` high in cycles 1..`Beats`.
  - Last rvalid at cycle `Beats`+1.
  - `axi_r_valid` high from cycle `Beats`+2.
- R handshake at cycle t means IDLE at t+1, and the earliest next AR handshake is at t+1.
- `axi_ar_ready` is 0 in FETCH and RESP.
- Reset mid-transaction:
  - Everything returns to IDLE and the line is discarded.
  - Late `mem_rvalid` pulses arriving after reset are dropped, because outstanding=0.

## Configuration
- Macro `XADAC_VLOAD_MEM_ALIGN_EN`.
- Defined: the latched base address has its low log2(`MemDataWidth`/8) bits cleared, so every `mem_addr` is word aligned.
- Undefined: the base address is used unmodified, and `mem_addr` may be unaligned. Alignment is then the memory's responsibility.

## Test plan
- **Basic load** (`MemDataWidth`=32, `VectorWidth`=128, gnt=1, rvalid +1 cycle).
  - Stimulus: AR id=3, addr=0x1000.
  - Required: `mem_addr` 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles.
  - Required: R id=3 with data {w3,w2,w1,w0} at cycle 6. `axi_ar_ready`=0 until the cycle after the R handshake.
- **Grant stall.**
  - Stimulus: `mem_gnt`=0 for 3 cycles on beat 1.
  - Required: `mem_addr` stays 0x1004 for those cycles. No extra beats are issued. The line is still assembled in order.
- **Outstanding limit.**
  - Stimulus: `MaxOutstanding`=2, rvalid delayed 5 cycles.
  - Required: `mem_req` drops after 2 grants and resumes only after the first rvalid.
- **R backpressure.**
  - Stimulus: `axi_r_ready`=0 for 4 cycles.
  - Required: `axi_r_valid`, id and data are held constant. A new AR presented meanwhile is not accepted.
- **Wrap and alignment.**
  - Stimulus: addr=0xFFFFFFFE with a 32-bit `AddrT`.
  - Required with the macro defined: addresses 0xFFFFFFFC, 0x0, 0x4, 0x8.
  - Required with the macro undefined: addresses 0xFFFFFFFE, 0x2, 0x6, 0xA.
- **Reset mid-fetch.**
  - Stimulus: assert `rstn`=0 after 2 grants, release, then drive 2 stray `mem_rvalid` pulses.
  - Required: all outputs return to their reset values. The stray rvalids are ignored. The next AR completes normally.

Source files
------------

// File: rtl/xadac_vload_mem.sv
// xadac_vload_mem: splits one AR vector-line read into Beats word reads
// on a pipelined OBI-style port and returns the assembled line on R.
// Ports: clk, rstn (async, active-low);
//   AR: axi_ar_id/addr/valid in, axi_ar_ready out;
//   R : axi_r_id/data/valid out, axi_r_ready in;
//   mem: mem_req/mem_addr out, mem_gnt/mem_rvalid/mem_rdata in.
// Macro XADAC_VLOAD_MEM_ALIGN_EN: word-align the latched base address.
package xadac_pkg;
    localparam int VectorWidth = 128;
    localparam int AddrWidth   = 32;
    localparam int IdWidth     = 4;
    typedef logic [IdWidth-1:0]     IdT;
    typedef logic [AddrWidth-1:0]   AddrT;
    typedef logic [VectorWidth-1:0] VecDataT;
endpackage

module xadac_vload_mem
    import xadac_pkg::*;
#(
    parameter int MemDataWidth   = 32,
    parameter int Beats          = VectorWidth / MemDataWidth,
    parameter int MaxOutstanding = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  IdT                      axi_ar_id,
    input  AddrT                    axi_ar_addr,
    input  logic                    axi_ar_valid,
    output logic                    axi_ar_ready,
    output IdT                      axi_r_id,
    output VecDataT                 axi_r_data,
    output logic                    axi_r_valid,
    input  logic                    axi_r_ready,
    output logic                    mem_req,
    output AddrT                    mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [MemDataWidth-1:0] mem_rdata
);
    localparam int ByteShift = $clog2(MemDataWidth / 8);
    localparam int CntW      = $clog2(Beats + 1);
    localparam int OutW      = $clog2(MaxOutstanding + 1);

`ifdef XADAC_VLOAD_MEM_ALIGN_EN
    localparam AddrT AlignMask = ~AddrT'((MemDataWidth / 8) - 1);
`else
    localparam AddrT AlignMask = '1;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t          state_q, state_d;
    IdT              id_q, id_d;
    AddrT            base_q, base_d;
    VecDataT         line_q, line_d;
    logic [CntW-1:0] issue_q, issue_d;
    logic [CntW-1:0] rx_q, rx_d;
    logic [OutW-1:0] out_q, out_d;
    logic            ready_q, ready_d;
    logic            req_q, req_d;
    AddrT            addr_q, addr_d;
    logic            gnt_ok;
    logic            rv_ok;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        base_d  = base_q;
        line_d  = line_q;
        issue_d = issue_q;
        rx_d    = rx_q;
        out_d   = out_q;
        gnt_ok  = req_q && mem_gnt;
        // rvalid with nothing outstanding is a stray and is dropped
        rv_ok   = mem_rvalid && (out_q != '0);

        unique case (state_q)
            IDLE: begin
                if (axi_ar_valid && ready_q) begin
                    id_d    = axi_ar_id;
                    base_d  = axi_ar_addr & AlignMask;
                    issue_d = '0;
                    rx_d    = '0;
                    line_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (gnt_ok) begin
                    issue_d = issue_q + 1'b1;
                end
                if (rv_ok) begin
                    for (int b = 0; b < Beats; b++) begin
                        if (rx_q == CntW'(b)) begin
                            line_d[b*MemDataWidth +: MemDataWidth] = mem_rdata;
                        end
                    end
                    rx_d = rx_q + 1'b1;
                end
                case ({gnt_ok, rv_ok})
                    2'b10:   out_d = out_q + 1'b1;
                    2'b01:   out_d = out_q - 1'b1;
                    default: out_d = out_q;
                endcase
                if (rx_d == CntW'(Beats)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (axi_r_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // outputs are registered from next-state values: no input-to-output path
        ready_d = (state_d == IDLE);
        req_d   = (state_d == FETCH)
                && (issue_d < CntW'(Beats))
                && (out_d < OutW'(MaxOutstanding));
        addr_d  = base_d + (AddrT'(issue_d) << ByteShift);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            id_q    <= '0;
            base_q  <= '0;
            line_q  <= '0;
            issue_q <= '0;
            rx_q    <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            base_q  <= base_d;
            line_q  <= line_d;
            issue_q <= issue_d;
            rx_q    <= rx_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign axi_ar_ready = ready_q;
    assign axi_r_valid  = (state_q == RESP);
    assign axi_r_id     = id_q;
    assign axi_r_data   = line_q;
    assign mem_req      = req_q;
    assign mem_addr     = addr_q;

endmodule

// File: tb/tb_xadac_vload_mem.sv
// tb_xadac_vload_mem: randomized scoreboard bench for xadac_vload_mem.
// Memory returns a hash of each granted address; lines are predicted from AR.
module tb_xadac_vload_mem;
    import xadac_pkg::*;

    localparam int MDW   = 32;
    localparam int BEATS = VectorWidth / MDW;
    localparam int MAXO  = 2;

    logic           clk = 1'b0;
    logic           rstn;
    IdT             axi_ar_id;
    AddrT           axi_ar_addr;
    logic           axi_ar_valid;
    logic           axi_ar_ready;
    IdT             axi_r_id;
    VecDataT        axi_r_data;
    logic           axi_r_valid;
    logic           axi_r_ready;
    logic           mem_req;
    AddrT           mem_addr;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [MDW-1:0] mem_rdata;

    always #5 clk = ~clk;

    xadac_vload_mem #(
        .MemDataWidth  (MDW),
        .MaxOutstanding(MAXO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .axi_ar_id   (axi_ar_id),
        .axi_ar_addr (axi_ar_addr),
        .axi_ar_valid(axi_ar_valid),
        .axi_ar_ready(axi_ar_ready),
        .axi_r_id    (axi_r_id),
        .axi_r_data  (axi_r_data),
        .axi_r_valid (axi_r_valid),
        .axi_r_ready (axi_r_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] memfn(input AddrT a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic AddrT base_of(input AddrT a);
`ifdef XADAC_VLOAD_MEM_ALIGN_EN
        return a & ~AddrT'(MDW / 8 - 1);
`else
        return a;
`endif
    endfunction

    IdT      sb_id[$];
    VecDataT sb_data[$];
    AddrT    exp_addr[$];
    AddrT    pend_a[$];
    int      pend_due[$];

    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int stall_left = 0;
    int txn_grants = 0;
    int stray_cnt = 0;
    int rr_pct = 100;
    bit chk_lat = 1'b0;
    int ar_cyc = 0;
    int r_cnt = 0;
    int out_m = 0;

    // memory responder: in-order data, latency counted from the grant cycle
    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (stall_left > 0 && mem_req && txn_grants == 1) begin
                mem_gnt = 1'b0;
                stall_left--;
            end else begin
                mem_gnt = ($urandom_range(0, 99) < gnt_pct);
            end
            if (stray_cnt > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = $urandom;
                stray_cnt--;
            end else if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata = memfn(pend_a.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        axi_r_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            axi_r_ready = ($urandom_range(0, 99) < rr_pct);
        end
    end

    // monitor: everything sampled mid-cycle, one half period before the edge
    logic    p_req, p_gnt, p_rv, p_rr, p_rhs;
    AddrT    p_addr;
    IdT      p_id;
    VecDataT p_data;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_ar_ready", axi_ar_ready, 0);
            chk("rst_r_valid", axi_r_valid, 0);
            chk("rst_r_id", axi_r_id, 0);
            chk("rst_r_data", axi_r_data, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_addr", mem_addr, 0);
            p_req = 0; p_gnt = 0; p_rv = 0; p_rr = 0; p_rhs = 0;
            out_m = 0;
            pend_a.delete();
            pend_due.delete();
            exp_addr.delete();
            sb_id.delete();
            sb_data.delete();
        end else begin
            logic rv_take;
            if (p_req && !p_gnt) begin
                chk("req_hold", mem_req, 1);
                chk("addr_hold", mem_addr, p_addr);
            end
            if (p_rv && !p_rr) begin
                chk("r_valid_hold", axi_r_valid, 1);
                chk("r_id_hold", axi_r_id, p_id);
                chk("r_data_hold", axi_r_data, p_data);
            end
            if (p_rhs) chk("ar_ready_after_r", axi_ar_ready, 1);
            if (mem_req || axi_r_valid) chk("ar_ready_busy", axi_ar_ready, 0);
            if (mem_req) chk("outstanding_limit", out_m < MAXO, 1);
            if (chk_lat && mem_req)
                chk("req_window", (cyc - ar_cyc >= 1) && (cyc - ar_cyc <= BEATS), 1);
            if (chk_lat && axi_r_valid && !p_rv)
                chk("r_latency", cyc - ar_cyc, BEATS + 2);

            if (axi_ar_valid && axi_ar_ready) begin
                AddrT    b;
                VecDataT l;
                b = base_of(axi_ar_addr);
                l = '0;
                for (int i = 0; i < BEATS; i++) begin
                    exp_addr.push_back(b + AddrT'(i * (MDW / 8)));
                    l[i*MDW +: MDW] = memfn(b + AddrT'(i * (MDW / 8)));
                end
                sb_id.push_back(axi_ar_id);
                sb_data.push_back(l);
                ar_cyc = cyc;
                txn_grants = 0;
            end

            rv_take = mem_rvalid && (out_m > 0);
            if (mem_req && mem_gnt) begin
                chk("beat_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0)
                    chk("mem_addr", mem_addr, exp_addr.pop_front());
                pend_a.push_back(mem_addr);
                pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                txn_grants++;
                out_m++;
            end
            if (rv_take) out_m--;

            if (axi_r_valid && axi_r_ready) begin
                chk("r_expected", sb_id.size() != 0, 1);
                if (sb_id.size() != 0) begin
                    chk("r_id", axi_r_id, sb_id.pop_front());
                    chk("r_data", axi_r_data, sb_data.pop_front());
                end
                r_cnt++;
            end

            p_req = mem_req;
            p_gnt = mem_gnt;
            p_addr = mem_addr;
            p_rv = axi_r_valid;
            p_rr = axi_r_ready;
            p_id = axi_r_id;
            p_data = axi_r_data;
            p_rhs = axi_r_valid && axi_r_ready;
        end
    end

    task automatic send_ar(input IdT id, input AddrT a);
        int k = 0;
        @(posedge clk);
        #2;
        axi_ar_valid = 1'b1;
        axi_ar_id = id;
        axi_ar_addr = a;
        @(negedge clk);
        #1;
        while (!axi_ar_ready && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("ar_accept", axi_ar_ready, 1);
        @(posedge clk);
        #2;
        axi_ar_valid = 1'b0;
        axi_ar_id = IdT'($urandom);
        axi_ar_addr = $urandom;
    endtask

    task automatic wait_r(input int n0);
        int k = 0;
        while (r_cnt <= n0 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("r_done", r_cnt > n0, 1);
    endtask

    task automatic run(input IdT id, input AddrT a);
        int r0;
        r0 = r_cnt;
        send_ar(id, a);
        wait_r(r0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int k;
        rstn = 1'b0;
        axi_ar_valid = 1'b0;
        axi_ar_id = '0;
        axi_ar_addr = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("ar_ready_first_cycle", axi_ar_ready, 1);

        chk_lat = 1'b1;
        run(4'd3, 32'h0000_1000);
        chk_lat = 1'b0;

        stall_left = 3;
        run(4'd4, 32'h0000_1000);

        lat_min = 5;
        lat_max = 5;
        run(4'd7, 32'h0000_2000);
        lat_min = 1;
        lat_max = 1;

        rr_pct = 0;
        r0 = r_cnt;
        send_ar(4'd5, 32'h0000_3000);
        k = 0;
        while (!axi_r_valid && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("bp_r_valid", axi_r_valid, 1);
        @(posedge clk);
        #2;
        axi_ar_valid = 1'b1;
        axi_ar_id = 4'd6;
        axi_ar_addr = 32'h0000_4000;
        repeat (4) @(negedge clk);
        #1;
        chk("bp_ar_blocked", axi_ar_ready, 0);
        chk("bp_r_count", r_cnt, r0);
        rr_pct = 100;
        k = 0;
        while (!axi_ar_ready && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("bp_ar_accept", axi_ar_ready, 1);
        @(posedge clk);
        #2;
        axi_ar_valid = 1'b0;
        wait_r(r0 + 1);

        run(4'd2, 32'hFFFF_FFFE);

        lat_min = 5;
        lat_max = 5;
        send_ar(4'd9, 32'h0000_5000);
        k = 0;
        while (txn_grants < 2 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rst_two_grants", txn_grants, 2);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ar_ready_after", axi_ar_ready, 1);
        lat_min = 1;
        lat_max = 1;
        r0 = r_cnt;
        stray_cnt = 2;
        repeat (5) @(negedge clk);
        #1;
        chk("stray_r_valid", axi_r_valid, 0);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_r_data", axi_r_data, 0);
        chk("stray_r_count", r_cnt, r0);
        run(4'd10, 32'h0000_6000);

        for (int t = 0; t < 25; t++) begin
            gnt_pct = $urandom_range(40, 100);
            lat_max = $urandom_range(1, 6);
            rr_pct = $urandom_range(30, 100);
            run(IdT'($urandom), AddrT'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
